// File: rtl/mem_access_unit.sv
// Load/store bus master: accepts one request from the execute stage, runs a single
// word-aligned bus transfer and reports exactly one one-cycle response pulse.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_store_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        bus_valid_out,
    output logic        bus_wr_out,
    output logic [31:0] bus_addr_out,
    output logic [3:0]  bus_wstrb_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_ready_in,
    input  logic [31:0] bus_rdata_in,
    input  logic        bus_err_in,
    output logic        ahb_resp_out,
    output logic [31:0] ld_data_out,
    output logic [1:0]  ld_addr_1_to_0_out,
    output logic [1:0]  ld_size_out,
    output logic        ld_unsigned_out,
    output logic        store_done_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

    // The abort fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        store_q, store_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_wr_q, bus_wr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_unsigned_q, ld_unsigned_d;
    logic        ahb_resp_q, ahb_resp_d;
    logic        store_done_q, store_done_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        misaligned_req;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        misaligned_req = 1'b0;
        lane_strb      = 4'b1111;
        lane_wdata     = req_wdata_in;
        case (req_size_in)
            2'b00: begin
                lane_strb  = 4'b0001 << req_addr_in[1:0];
                lane_wdata = {4{req_wdata_in[7:0]}};
            end
            2'b01: begin
                lane_strb      = req_addr_in[1] ? 4'b1100 : 4'b0011;
                lane_wdata     = {2{req_wdata_in[15:0]}};
                misaligned_req = req_addr_in[0];
            end
            default: misaligned_req = (req_addr_in[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        store_d       = store_q;
        bus_valid_d   = bus_valid_q;
        bus_wr_d      = bus_wr_q;
        bus_addr_d    = bus_addr_q;
        bus_wstrb_d   = bus_wstrb_q;
        bus_wdata_d   = bus_wdata_q;
        ld_data_d     = ld_data_q;
        ld_addr_d     = ld_addr_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        ahb_resp_d    = 1'b0;
        store_done_d  = 1'b0;
        misaligned_d  = 1'b0;
        bus_error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    store_d = req_store_in;
                    // Load attributes only move on a new load so the load unit sees stable fields.
                    if (!req_store_in) begin
                        ld_addr_d     = req_addr_in[1:0];
                        ld_size_d     = req_size_in;
                        ld_unsigned_d = req_unsigned_in;
                    end
                    if (misaligned_req) begin
                        misaligned_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d     = BUSY;
                        wait_d      = 8'd0;
                        bus_valid_d = 1'b1;
                        bus_wr_d    = req_store_in;
                        bus_addr_d  = {req_addr_in[31:2], 2'b00};
                        bus_wstrb_d = req_store_in ? lane_strb : 4'b0000;
                        bus_wdata_d = req_store_in ? lane_wdata : 32'h0;
                    end
                end
            end
            BUSY: begin
                if (bus_ready_in) begin
                    state_d     = RESP;
                    bus_valid_d = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    if (bus_err_in) begin
                        bus_error_d = 1'b1;
                    end else if (store_q) begin
                        store_done_d = 1'b1;
                    end else begin
                        ahb_resp_d = 1'b1;
                        ld_data_d  = bus_rdata_in;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d     = RESP;
                    bus_valid_d = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    bus_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; rst_n_in is sampled on the clock edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            store_q       <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_wstrb_q   <= 4'b0000;
            bus_wdata_q   <= 32'h0;
            ld_data_q     <= 32'h0;
            ld_addr_q     <= 2'b00;
            ld_size_q     <= 2'b00;
            ld_unsigned_q <= 1'b0;
            ahb_resp_q    <= 1'b0;
            store_done_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            store_q       <= store_d;
            bus_valid_q   <= bus_valid_d;
            bus_wr_q      <= bus_wr_d;
            bus_addr_q    <= bus_addr_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_wdata_q   <= bus_wdata_d;
            ld_data_q     <= ld_data_d;
            ld_addr_q     <= ld_addr_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
            ahb_resp_q    <= ahb_resp_d;
            store_done_q  <= store_done_d;
            misaligned_q  <= misaligned_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign req_ready_out      = (state_q == IDLE);
    assign bus_valid_out      = bus_valid_q;
    assign bus_wr_out         = bus_wr_q;
    assign bus_addr_out       = bus_addr_q;
    assign bus_wstrb_out      = bus_wstrb_q;
    assign bus_wdata_out      = bus_wdata_q;
    assign ahb_resp_out       = ahb_resp_q;
    assign ld_data_out        = ld_data_q;
    assign ld_addr_1_to_0_out = ld_addr_q;
    assign ld_size_out        = ld_size_q;
    assign ld_unsigned_out    = ld_unsigned_q;
    assign store_done_out     = store_done_q;
    assign misaligned_out     = misaligned_q;
    assign bus_error_out      = bus_error_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected bus transfers
// and response pulses; independent monitors pop and compare when the DUT presents them.
module tb_mem_access_unit;
    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_LD   = 4'b1000;
    localparam logic [3:0] K_ST   = 4'b0100;
    localparam logic [3:0] K_MIS  = 4'b0010;
    localparam logic [3:0] K_ERR  = 4'b0001;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] rd;
        logic        er;
        logic [3:0]  kind;
        int          off;    // edges from the accept edge until the response pulse is visible
        logic        has_bus;
        logic [31:0] baddr;
        logic [3:0]  bstrb;
        logic [31:0] bwdata;
        int          blen;
    } vec_t;

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] ld_data;
        logic [1:0]  ld_a;
        logic [1:0]  ld_sz;
        logic        ld_u;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          len;
        int          cyc;
    } bus_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in, req_ready_out, req_store_in, req_unsigned_in;
    logic [1:0]  req_size_in;
    logic [31:0] req_addr_in, req_wdata_in;
    logic        bus_valid_out, bus_wr_out;
    logic [31:0] bus_addr_out, bus_wdata_out;
    logic [3:0]  bus_wstrb_out;
    logic        bus_ready_in, bus_err_in;
    logic [31:0] bus_rdata_in;
    logic        ahb_resp_out, ld_unsigned_out, store_done_out, misaligned_out, bus_error_out;
    logic [31:0] ld_data_out;
    logic [1:0]  ld_addr_1_to_0_out, ld_size_out;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    vec_t  vecs[$];
    resp_t resp_q[$];
    bus_t  bus_q[$];

    // Slave configuration and reference model of the load-unit fields.
    int          sl_waits = 0;
    logic [31:0] sl_rdata = 32'h0;
    logic        sl_err = 1'b0;
    logic [31:0] m_d = 32'h0;
    logic [1:0]  m_a = 2'b00;
    logic [1:0]  m_sz = 2'b00;
    logic        m_u = 1'b0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_store_in(req_store_in), .req_size_in(req_size_in),
        .req_unsigned_in(req_unsigned_in), .req_addr_in(req_addr_in),
        .req_wdata_in(req_wdata_in),
        .bus_valid_out(bus_valid_out), .bus_wr_out(bus_wr_out),
        .bus_addr_out(bus_addr_out), .bus_wstrb_out(bus_wstrb_out),
        .bus_wdata_out(bus_wdata_out), .bus_ready_in(bus_ready_in),
        .bus_rdata_in(bus_rdata_in), .bus_err_in(bus_err_in),
        .ahb_resp_out(ahb_resp_out), .ld_data_out(ld_data_out),
        .ld_addr_1_to_0_out(ld_addr_1_to_0_out), .ld_size_out(ld_size_out),
        .ld_unsigned_out(ld_unsigned_out), .store_done_out(store_done_out),
        .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input logic st, input logic [1:0] sz, input logic u, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd, input logic er,
                           input logic [3:0] kind, input int off, input logic has_bus,
                           input logic [31:0] baddr, input logic [3:0] bstrb, input logic [31:0] bwdata,
                           input int blen);
        vec_t v;
        v.st = st; v.sz = sz; v.u = u; v.a = a; v.wd = wd; v.waits = waits; v.rd = rd; v.er = er;
        v.kind = kind; v.off = off; v.has_bus = has_bus; v.baddr = baddr; v.bstrb = bstrb;
        v.bwdata = bwdata; v.blen = blen;
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        @(negedge clk_in);
        for (int n = 0; n < 200 && req_ready_out !== 1'b1; n++) @(negedge clk_in);
        check("req_ready_wait", {31'b0, req_ready_out}, 32'h1);
    endtask

    task automatic issue(input vec_t v);
        resp_t r;
        bus_t  b;
        wait_ready();
        sl_waits        = v.waits;
        sl_rdata        = v.rd;
        sl_err          = v.er;
        req_store_in    = v.st;
        req_size_in     = v.sz;
        req_unsigned_in = v.u;
        req_addr_in     = v.a;
        req_wdata_in    = v.wd;
        req_valid_in    = 1'b1;
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        if (!v.st) begin
            m_a  = v.a[1:0];
            m_sz = v.sz;
            m_u  = v.u;
            if (v.kind == K_LD) m_d = v.rd;
        end
        if (v.kind != K_NONE) begin
            r.kind = v.kind; r.ld_data = m_d; r.ld_a = m_a; r.ld_sz = m_sz; r.ld_u = m_u;
            r.cyc = cyc + v.off;
            resp_q.push_back(r);
        end
        if (v.has_bus) begin
            b.addr = v.baddr; b.wr = v.st; b.strb = v.bstrb; b.wdata = v.bwdata;
            b.len = v.blen; b.cyc = cyc;
            bus_q.push_back(b);
        end
    endtask

    // Bus slave plus bus-side monitor.
    initial begin
        int   sl_cnt;
        int   bus_len;
        logic have_b;
        bus_t cur_b;
        sl_cnt = 0; bus_len = 0; have_b = 1'b0;
        bus_ready_in = 1'b0; bus_err_in = 1'b0; bus_rdata_in = 32'h0;
        forever begin
            @(negedge clk_in);
            if (bus_valid_out === 1'b1) begin
                bus_ready_in = (sl_cnt == sl_waits);
                bus_err_in   = bus_ready_in & sl_err;
                bus_rdata_in = bus_ready_in ? sl_rdata : 32'hBAD0_BAD0;
                if (bus_len == 0) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_valid", {31'b0, bus_valid_out}, 32'h0);
                    end else begin
                        cur_b  = bus_q.pop_front();
                        have_b = 1'b1;
                        check("bus_start_cycle", cyc, cur_b.cyc);
                        check("bus_addr", bus_addr_out, cur_b.addr);
                        check("bus_wr", {31'b0, bus_wr_out}, {31'b0, cur_b.wr});
                        check("bus_wstrb", {28'b0, bus_wstrb_out}, {28'b0, cur_b.strb});
                        if (cur_b.wr) check("bus_wdata", bus_wdata_out, cur_b.wdata);
                    end
                end else if (have_b) begin
                    check("bus_addr_hold", bus_addr_out, cur_b.addr);
                    check("bus_wstrb_hold", {28'b0, bus_wstrb_out}, {28'b0, cur_b.strb});
                    if (cur_b.wr) check("bus_wdata_hold", bus_wdata_out, cur_b.wdata);
                end
                sl_cnt++;
                bus_len++;
            end else begin
                bus_ready_in = 1'b0;
                bus_err_in   = 1'b0;
                sl_cnt       = 0;
                if (bus_len != 0 && have_b) check("bus_valid_cycles", bus_len, cur_b.len);
                bus_len = 0;
                have_b  = 1'b0;
                check("wstrb_when_idle", {28'b0, bus_wstrb_out}, 32'h0);
            end
        end
    end

    // Response monitor: any pulse pops the scoreboard and is compared in full.
    initial begin
        logic [3:0] p;
        resp_t      e;
        forever begin
            @(negedge clk_in);
            p = {ahb_resp_out, store_done_out, misaligned_out, bus_error_out};
            if (p !== 4'b0000) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_pulse", {28'b0, p}, 32'h0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_kind", {28'b0, p}, {28'b0, e.kind});
                    check("resp_cycle", cyc, e.cyc);
                    check("ld_data", ld_data_out, e.ld_data);
                    check("ld_addr", {30'b0, ld_addr_1_to_0_out}, {30'b0, e.ld_a});
                    check("ld_size", {30'b0, ld_size_out}, {30'b0, e.ld_sz});
                    check("ld_unsigned", {31'b0, ld_unsigned_out}, {31'b0, e.ld_u});
                end
            end
        end
    end

    initial begin
        rst_n_in = 1'b0; req_valid_in = 1'b0; req_store_in = 1'b0; req_size_in = 2'b00;
        req_unsigned_in = 1'b0; req_addr_in = 32'h0; req_wdata_in = 32'h0;

        //       st  sz     u     addr          wdata         w  rdata         er   kind   off bus  baddr        strb     bwdata        len
        add_vec(1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0,        1'b0, K_ST,  1, 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1);
        add_vec(0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         2, 32'h8001_7FFF, 1'b0, K_LD,  3, 1, 32'h0000_2000, 4'b0000, 32'h0,         3);
        add_vec(0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,         0, 32'h0,        1'b0, K_MIS, 0, 0, 32'h0,         4'b0000, 32'h0,         0);
        add_vec(1, 2'b01, 1'b0, 32'h0000_4002, 32'h1234_5678, 1, 32'h0,        1'b0, K_ST,  2, 1, 32'h0000_4000, 4'b1100, 32'h5678_5678, 2);
        add_vec(1, 2'b10, 1'b0, 32'h0000_5000, 32'hDEAD_BEEF, 0, 32'h0,        1'b0, K_ST,  1, 1, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 1);
        add_vec(0, 2'b00, 1'b1, 32'h0000_6001, 32'h0,         0, 32'h1122_3344, 1'b0, K_LD,  1, 1, 32'h0000_6000, 4'b0000, 32'h0,         1);
        add_vec(1, 2'b01, 1'b0, 32'h0000_7001, 32'h0000_BEEF, 0, 32'h0,        1'b0, K_MIS, 0, 0, 32'h0,         4'b0000, 32'h0,         0);
        add_vec(0, 2'b11, 1'b0, 32'h0000_8004, 32'h0,         1, 32'hFFFF_FFFF, 1'b1, K_ERR, 2, 1, 32'h0000_8004, 4'b0000, 32'h0,         2);
        add_vec(1, 2'b00, 1'b0, 32'h0000_9000, 32'h0000_005A, 0, 32'h0,        1'b0, K_ST,  1, 1, 32'h0000_9000, 4'b0001, 32'h5A5A_5A5A, 1);
        add_vec(1, 2'b00, 1'b0, 32'h0000_B002, 32'h0000_0077, 0, 32'h0,        1'b0, K_ST,  1, 1, 32'h0000_B000, 4'b0100, 32'h7777_7777, 1);
        // Load held in BUSY then reset after four bus_valid cycles: no response expected.
        add_vec(0, 2'b10, 1'b0, 32'h0000_C000, 32'h0,      1000, 32'h0,        1'b0, K_NONE, 0, 1, 32'h0000_C000, 4'b0000, 32'h0,         4);
        // Slave never answers: abort after 16 BUSY wait cycles.
        add_vec(0, 2'b10, 1'b0, 32'h0000_A000, 32'h0,      1000, 32'h0,        1'b0, K_ERR, 16, 1, 32'h0000_A000, 4'b0000, 32'h0,        16);

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_bus_valid", {31'b0, bus_valid_out}, 32'h0);
        check("rst_pulses", {28'b0, ahb_resp_out, store_done_out, misaligned_out, bus_error_out}, 32'h0);
        check("rst_ld_data", ld_data_out, 32'h0);
        check("rst_bus_addr", bus_addr_out, 32'h0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("rst_ready", {31'b0, req_ready_out}, 32'h1);

        for (int i = 0; i < 10; i++) issue(vecs[i]);

        issue(vecs[10]);
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("midbusy_rst_bus_valid", {31'b0, bus_valid_out}, 32'h0);
        check("midbusy_rst_ready", {31'b0, req_ready_out}, 32'h1);
        check("midbusy_rst_ld_data", ld_data_out, 32'h0);
        rst_n_in = 1'b1;
        m_d = 32'h0; m_a = 2'b00; m_sz = 2'b00; m_u = 1'b0;

        issue(vecs[11]);

        for (int n = 0; n < 100 && (resp_q.size() != 0 || req_ready_out !== 1'b1); n++) @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        check("resp_queue_drained", resp_q.size(), 32'h0);
        check("bus_queue_drained", bus_q.size(), 32'h0);
        check("final_ready", {31'b0, req_ready_out}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
